acc_bank: RTL

Parametrised multi-channel accumulator bank. It is the next generation of the single 16-bit accumulator in the generalised processor datapath.
- Holds NACC accumulators, each DW bits wide.
- Loads from an immediate, from register-file read data (rd_data) or from the ALU/FPU result (res_out).
- Adds saturating signed add/sub, shift and clear operations.
- Adds a LIFO context stack for save/restore of accumulators across subroutine calls.
- Sits between the register file, the ALU result bus and the control unit.

---
 rtl/acc_pkg.sv | 25 ++
 rtl/acc_lifo.sv | 76 +++++++
 rtl/acc_bank.sv | 120 ++++++++++++
 3 files changed

// File: rtl/acc_pkg.sv
// ============================================================================
// acc_pkg : op-code constants and saturation helper for the accumulator bank
// Rev 1.0
// ============================================================================
`default_nettype none

package acc_pkg;

    localparam logic [2:0] OP_LDI   = 3'b000;
    localparam logic [2:0] OP_LDR   = 3'b001;
    localparam logic [2:0] OP_LDRES = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_SHL   = 3'b101;
    localparam logic [2:0] OP_SAR   = 3'b110;
    localparam logic [2:0] OP_CLR   = 3'b111;

    // top = two MSBs of a DW+1 bit sign-extended result; returns {overflow, clamp_negative}
    function automatic logic [1:0] sat_chk(input logic [1:0] top);
        return {top[1] ^ top[0], top[1]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_lifo.sv
// ============================================================================
// acc_lifo : context stack with count, full/empty and sticky error detection
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_lifo #(
    parameter int DW          = 16,
    parameter int STACK_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clr_err_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o,
    output logic          pop_ok_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          err_o
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int PW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [DW-1:0] mem_q [STACK_DEPTH];

    logic          w_push_ok;
    logic          w_err_evt;
    logic [PW-1:0] w_wr_idx;
    logic [PW-1:0] w_rd_idx;

    assign full_o   = (cnt_q == CW'(STACK_DEPTH));
    assign empty_o  = (cnt_q == '0);
    assign err_o    = err_q;

    assign w_push_ok = push_i & ~pop_i & ~full_o;
    assign pop_ok_o  = pop_i & ~push_i & ~empty_o;
    assign w_err_evt = (push_i & pop_i) | (push_i & full_o) | (pop_i & empty_o);

    assign w_wr_idx = PW'(cnt_q);
    assign w_rd_idx = PW'(cnt_q - CW'(1));
    assign rdata_o  = mem_q[w_rd_idx];

    always_comb begin
        cnt_d = cnt_q;
        if (w_push_ok)
            cnt_d = cnt_q + CW'(1);
        else if (pop_ok_o)
            cnt_d = cnt_q - CW'(1);
        // A fresh error takes priority over a simultaneous clear
        err_d = w_err_evt ? 1'b1 : (clr_err_i ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Storage is deliberately left out of reset; only the count qualifies it
    always_ff @(posedge clk) begin
        if (w_push_ok)
            mem_q[w_wr_idx] <= wdata_i;
    end

endmodule

`default_nettype wire

// File: rtl/acc_bank.sv
// ============================================================================
// acc_bank : NACC-entry saturating accumulator bank with context stack
// Rev 1.0
// ============================================================================
`default_nettype none

module acc_bank
    import acc_pkg::*;
#(
    parameter int DW          = 16,
    parameter int IMMW        = 8,
    parameter int NACC        = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    loadacc,
    input  logic [2:0]              selacc,
    input  logic [$clog2(NACC)-1:0] acc_sel,
    input  logic [IMMW-1:0]         immediate,
    input  logic                    imm_sext,
    input  logic [DW-1:0]           rd_data,
    input  logic [DW-1:0]           res_out,
    input  logic                    push,
    input  logic                    pop,
    input  logic                    clr_err,
    output logic [DW-1:0]           acc_data,
    output logic                    zero_flag,
    output logic                    neg_flag,
    output logic                    sat_flag,
    output logic                    stk_full,
    output logic                    stk_empty,
    output logic                    stk_err
);

    localparam logic [DW-1:0] C_MAXPOS = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0] C_MAXNEG = {1'b1, {(DW-1){1'b0}}};

    logic [DW-1:0] acc_q [NACC];
    logic [DW-1:0] acc_d [NACC];
    logic          sat_q, sat_d;

    logic [DW-1:0] w_cur;
    logic [DW-1:0] w_imm;
    logic [DW:0]   w_add;
    logic [DW:0]   w_sub;
    logic [DW:0]   w_as;
    logic [1:0]    w_chk;
    logic [DW-1:0] w_top;
    logic          w_pop_ok;

    acc_lifo #(
        .DW          (DW),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_lifo (
        .clk       (clk),
        .rstn      (rstn),
        .push_i    (push),
        .pop_i     (pop),
        .clr_err_i (clr_err),
        .wdata_i   (w_cur),
        .rdata_o   (w_top),
        .pop_ok_o  (w_pop_ok),
        .full_o    (stk_full),
        .empty_o   (stk_empty),
        .err_o     (stk_err)
    );

    assign w_cur     = acc_q[acc_sel];
    assign acc_data  = w_cur;
    assign zero_flag = (w_cur == '0);
    assign neg_flag  = w_cur[DW-1];
    assign sat_flag  = sat_q;

    assign w_imm = imm_sext ? DW'($signed(immediate)) : DW'(immediate);
    assign w_add = {w_cur[DW-1], w_cur} + {rd_data[DW-1], rd_data};
    assign w_sub = {w_cur[DW-1], w_cur} - {rd_data[DW-1], rd_data};
    assign w_as  = (selacc == OP_SUB) ? w_sub : w_add;
    assign w_chk = sat_chk(w_as[DW:DW-1]);

    always_comb begin
        acc_d = acc_q;
        sat_d = 1'b0;
        // Any pop request suppresses a concurrent load, even if the pop itself is rejected
        if (w_pop_ok) begin
            acc_d[acc_sel] = w_top;
        end else if (loadacc && !pop) begin
            case (selacc)
                OP_LDI:   acc_d[acc_sel] = w_imm;
                OP_LDR:   acc_d[acc_sel] = rd_data;
                OP_LDRES: acc_d[acc_sel] = res_out;
                OP_ADD, OP_SUB: begin
                    if (w_chk[1]) begin
                        acc_d[acc_sel] = w_chk[0] ? C_MAXNEG : C_MAXPOS;
                        sat_d          = 1'b1;
                    end else begin
                        acc_d[acc_sel] = w_as[DW-1:0];
                    end
                end
                OP_SHL:   acc_d[acc_sel] = {w_cur[DW-2:0], 1'b0};
                OP_SAR:   acc_d[acc_sel] = {w_cur[DW-1], w_cur[DW-1:1]};
                default:  acc_d[acc_sel] = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NACC; i++)
                acc_q[i] <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

endmodule

`default_nettype wire
